i2c_reg_xfer: RTL and testbench
===============================

Name: i2c_reg_xfer

Overview:
- Upstream command sequencer for the I2C master core. It turns a single host request (one register write, or one register read) into the master's byte-level command stream.
- Write request stream: START, WRITE, WRITE, WRITE, STOP.
- Read request stream: START, WRITE, WRITE, RESTART, WRITE, READ, STOP.
- Drives the master's write/cmd/data_in/nack inputs, paced by the master's ready_out. Returns read data and an ACK-error flag to the host.

Parameters:
- TIMEOUT_CYCLES, 16'd50000, max cycles to wait on any single master handshake phase before aborting with error.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- start_in  input  1  host request strobe; sampled only when busy_out=0
- rw_in  input  1  1=register read, 0=register write; latched with start_in
- dev_addr_in  input  7  7-bit device address; latched with start_in
- reg_addr_in  input  8  register address; latched with start_in
- wdata_in  input  8  write data; latched with start_in
- busy_out  output  1  high from the cycle after an accepted start_in until done_out
- done_out  output  1  one-cycle pulse when the transaction ends (success or error)
- err_out  output  1  valid with done_out, held until next accepted start_in; 1 = NACK or timeout
- rdata_out  output  8  byte read; updated only on a successful read, held otherwise
- mst_write_out  output  1  one-cycle command strobe to master write
- mst_cmd_out  output  3  command to master cmd (k_*_CMD from include/i2c.vh)
- mst_data_out  output  8  byte to master data_in
- mst_nack_out  output  1  to master nack
- mst_ready_in  input  1  master ready_out
- mst_rx_data_in  input  8  byte received by master's last READ
- mst_ack_in  input  1  1 = slave ACKed master's last WRITE byte

Behaviour:
- Reset: busy_out=0, done_out=0, err_out=0, rdata_out=8'h00, mst_write_out=0, mst_cmd_out=k_STOP_CMD, mst_data_out=8'h00, mst_nack_out=0; FSM to IDLE, step=0.
- FSM states: IDLE, ISSUE, WAIT_LO, WAIT_HI, CHECK, DONE. A 3-bit step index selects the command from a per-direction step table.
- Write table: 0 START; 1 WRITE {dev,0}; 2 WRITE reg; 3 WRITE wdata; 4 STOP.
- Read table: 0 START; 1 WRITE {dev,0}; 2 WRITE reg; 3 RESTART; 4 WRITE {dev,1}; 5 READ; 6 STOP.
- WRITE steps: mst_nack_out=1 so SDA is released for the slave ACK.
- READ step: mst_data_out=8'hFF and mst_nack_out=1, so the master NACKs the single byte.
- START/RESTART/STOP steps: mst_data_out=8'h00 and mst_nack_out=0.
- IDLE: start_in=1 latches rw/dev/reg/wdata, clears err_out, sets step=0 and busy_out=1 next cycle, then goes to ISSUE. start_in while busy is ignored.
- ISSUE: wait for mst_ready_in=1. Then drive mst_write_out=1 for exactly one cycle with cmd/data/nack stable in that cycle, and go to WAIT_LO.
- WAIT_LO: wait for mst_ready_in=0 (master accepted). Then go to WAIT_HI.
- WAIT_HI: wait for mst_ready_in=1 (command complete). Then go to CHECK.
- CHECK, WRITE step with mst_ack_in=0: set err_out=1 and jump step to the STOP entry (4 or 6), then go to ISSUE.
- CHECK, READ step: register mst_rx_data_in into a shadow byte.
- CHECK, STOP step: go to DONE.
- CHECK, otherwise: step+1, go to ISSUE.
- DONE: done_out=1 for one cycle; rdata_out<=shadow if rw=1 and err_out=0; busy_out=0 next cycle; return to IDLE.
- mst_cmd_out, mst_data_out and mst_nack_out hold their last values outside strobe cycles.
- Timeout: a 16-bit counter clears on every state change. If it reaches TIMEOUT_CYCLES in ISSUE, WAIT_LO or WAIT_HI, set err_out=1 and go straight to DONE; no STOP is attempted because the master is unresponsive.
- Latency: done_out asserts exactly 1 cycle after the CHECK that processed STOP.
- NACK on the STOP path itself is impossible; mst_ack_in is ignored for non-WRITE steps.
- rst_in mid-transaction: immediate return to reset values. The bus may be left mid-frame; the master's own reset handles the bus.
- start_in in the same cycle as done_out: ignored (not IDLE).

Decomposition:
- Package/include include/i2c.vh gains k_XFER_* state constants and step-table index constants k_STEP_STOP_WR=4 and k_STEP_STOP_RD=6.
- Existing k_START_CMD, k_RESTART_CMD, k_STOP_CMD, k_READ_CMD and k_WRITE_CMD are reused unchanged.
- Step-table lookup is a pure function in hw/xfer_step.v; it maps (rw, step, dev, reg, wdata) to {cmd, data, nack}.
- No sub-module.

Test Plan:
- Mock master: ready drops 2 cycles after the strobe and rises 10 cycles later; always ACKs.
- Write, dev 7'h50, reg 8'h10, data 8'hA5 -> strobes in order START, WRITE 8'hA0 nack=1, WRITE 8'h10, WRITE 8'hA5, STOP; done_out one pulse; err_out=0; busy_out high throughout.
- Read, dev 7'h50, reg 8'h22, mock rx 8'h3C -> START, WRITE 8'hA0, WRITE 8'h22, RESTART, WRITE 8'hA1, READ data 8'hFF nack=1, STOP; rdata_out=8'h3C; err_out=0.
- Read with mst_ack_in=0 on the address byte -> next strobe is STOP (step 6); err_out=1; rdata_out keeps its prior value 8'h3C.
- mst_ready_in stuck high after strobe, TIMEOUT_CYCLES=100 -> done_out exactly 100 cycles after entering WAIT_LO; err_out=1; no STOP strobe.
- start_in pulsed while busy, then rst_in asserted mid-read -> second request ignored; after reset all outputs at reset values and busy_out=0 next cycle.

Source files
------------

// File: rtl/i2c_reg_xfer_pkg.sv
// Shared encodings for the I2C register-transfer sequencer: master command codes,
// sequencer states, STOP step indices and the per-direction step-table lookup.
package i2c_reg_xfer_pkg;

  localparam logic [2:0] k_START_CMD   = 3'd1;
  localparam logic [2:0] k_STOP_CMD    = 3'd2;
  localparam logic [2:0] k_READ_CMD    = 3'd3;
  localparam logic [2:0] k_WRITE_CMD   = 3'd4;
  localparam logic [2:0] k_RESTART_CMD = 3'd5;

  localparam logic [2:0] k_STEP_STOP_WR = 3'd4;
  localparam logic [2:0] k_STEP_STOP_RD = 3'd6;

  typedef enum logic [2:0] {
    k_XFER_IDLE,
    k_XFER_ISSUE,
    k_XFER_WAIT_LO,
    k_XFER_WAIT_HI,
    k_XFER_CHECK,
    k_XFER_DONE
  } xfer_state_t;

  typedef struct packed {
    logic [2:0] cmd;
    logic [7:0] data;
    logic       nack;
  } step_t;

  // WRITE steps release SDA for the slave ACK; the single READ byte is NACKed.
  function automatic step_t xfer_step(input logic       rw,
                                      input logic [2:0] step,
                                      input logic [6:0] dev,
                                      input logic [7:0] reg_addr,
                                      input logic [7:0] wdata);
    step_t s;
    s = '{cmd: k_STOP_CMD, data: 8'h00, nack: 1'b0};
    if (!rw) begin
      case (step)
        3'd0:    s.cmd = k_START_CMD;
        3'd1:    s = '{cmd: k_WRITE_CMD, data: {dev, 1'b0}, nack: 1'b1};
        3'd2:    s = '{cmd: k_WRITE_CMD, data: reg_addr, nack: 1'b1};
        3'd3:    s = '{cmd: k_WRITE_CMD, data: wdata, nack: 1'b1};
        default: s.cmd = k_STOP_CMD;
      endcase
    end else begin
      case (step)
        3'd0:    s.cmd = k_START_CMD;
        3'd1:    s = '{cmd: k_WRITE_CMD, data: {dev, 1'b0}, nack: 1'b1};
        3'd2:    s = '{cmd: k_WRITE_CMD, data: reg_addr, nack: 1'b1};
        3'd3:    s.cmd = k_RESTART_CMD;
        3'd4:    s = '{cmd: k_WRITE_CMD, data: {dev, 1'b1}, nack: 1'b1};
        3'd5:    s = '{cmd: k_READ_CMD, data: 8'hFF, nack: 1'b1};
        default: s.cmd = k_STOP_CMD;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/i2c_reg_xfer.sv
// Sequences one host register read/write into I2C master commands, paced by master ready.
// done_out fires one cycle after the STOP check; a stalled handshake phase aborts after TIMEOUT_CYCLES.
module i2c_reg_xfer
  import i2c_reg_xfer_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic       rw_in,
  input  logic [6:0] dev_addr_in,
  input  logic [7:0] reg_addr_in,
  input  logic [7:0] wdata_in,
  output logic       busy_out,
  output logic       done_out,
  output logic       err_out,
  output logic [7:0] rdata_out,
  output logic       mst_write_out,
  output logic [2:0] mst_cmd_out,
  output logic [7:0] mst_data_out,
  output logic       mst_nack_out,
  input  logic       mst_ready_in,
  input  logic [7:0] mst_rx_data_in,
  input  logic       mst_ack_in
);

  xfer_state_t r_state;
  xfer_state_t w_state_nxt;

  logic        r_rw;
  logic [6:0]  r_dev;
  logic [7:0]  r_reg;
  logic [7:0]  r_wdata;
  logic [2:0]  r_step;
  logic [7:0]  r_shadow;
  logic [15:0] r_tmo_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [7:0]  r_rdata;
  logic        r_mst_write;
  logic [2:0]  r_mst_cmd;
  logic [7:0]  r_mst_data;
  logic        r_mst_nack;

  step_t       w_cur;
  logic        w_tmo;
  logic        w_nack_err;
  logic        w_in_wait;
  logic [2:0]  w_stop_step;

  assign w_cur       = xfer_step(r_rw, r_step, r_dev, r_reg, r_wdata);
  assign w_tmo       = (r_tmo_cnt >= (TIMEOUT_CYCLES - 16'd1));
  assign w_nack_err  = (w_cur.cmd == k_WRITE_CMD) && !mst_ack_in;
  assign w_stop_step = r_rw ? k_STEP_STOP_RD : k_STEP_STOP_WR;
  assign w_in_wait   = (r_state == k_XFER_ISSUE) || (r_state == k_XFER_WAIT_LO) ||
                       (r_state == k_XFER_WAIT_HI);

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= k_XFER_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A stalled handshake goes straight to DONE: the master is unresponsive, so no STOP.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      k_XFER_IDLE:    if (start_in) w_state_nxt = k_XFER_ISSUE;
      k_XFER_ISSUE: begin
        if (mst_ready_in) w_state_nxt = k_XFER_WAIT_LO;
        else if (w_tmo)   w_state_nxt = k_XFER_DONE;
      end
      k_XFER_WAIT_LO: begin
        if (!mst_ready_in) w_state_nxt = k_XFER_WAIT_HI;
        else if (w_tmo)    w_state_nxt = k_XFER_DONE;
      end
      k_XFER_WAIT_HI: begin
        if (mst_ready_in) w_state_nxt = k_XFER_CHECK;
        else if (w_tmo)   w_state_nxt = k_XFER_DONE;
      end
      k_XFER_CHECK:   w_state_nxt = (w_cur.cmd == k_STOP_CMD) ? k_XFER_DONE : k_XFER_ISSUE;
      k_XFER_DONE:    w_state_nxt = k_XFER_IDLE;
      default:        w_state_nxt = k_XFER_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rw        <= 1'b0;
      r_dev       <= 7'h00;
      r_reg       <= 8'h00;
      r_wdata     <= 8'h00;
      r_step      <= 3'd0;
      r_shadow    <= 8'h00;
      r_tmo_cnt   <= 16'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 8'h00;
      r_mst_write <= 1'b0;
      r_mst_cmd   <= k_STOP_CMD;
      r_mst_data  <= 8'h00;
      r_mst_nack  <= 1'b0;
    end else begin
      r_mst_write <= 1'b0;
      r_done      <= (w_state_nxt == k_XFER_DONE);

      if (w_state_nxt != r_state)   r_tmo_cnt <= 16'd0;
      else if (r_tmo_cnt != 16'hFFFF) r_tmo_cnt <= r_tmo_cnt + 16'd1;

      if (w_in_wait && (w_state_nxt == k_XFER_DONE)) r_err <= 1'b1;

      case (r_state)
        k_XFER_IDLE: begin
          if (start_in) begin
            r_rw    <= rw_in;
            r_dev   <= dev_addr_in;
            r_reg   <= reg_addr_in;
            r_wdata <= wdata_in;
            r_err   <= 1'b0;
            r_step  <= 3'd0;
            r_busy  <= 1'b1;
          end
        end
        k_XFER_ISSUE: begin
          if (mst_ready_in) begin
            r_mst_write <= 1'b1;
            r_mst_cmd   <= w_cur.cmd;
            r_mst_data  <= w_cur.data;
            r_mst_nack  <= w_cur.nack;
          end
        end
        k_XFER_CHECK: begin
          if (w_nack_err) begin
            r_err  <= 1'b1;
            r_step <= w_stop_step;
          end else if (w_cur.cmd != k_STOP_CMD) begin
            r_step <= r_step + 3'd1;
          end
          if (w_cur.cmd == k_READ_CMD) r_shadow <= mst_rx_data_in;
        end
        k_XFER_DONE: begin
          if (r_rw && !r_err) r_rdata <= r_shadow;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy_out      = r_busy;
  assign done_out      = r_done;
  assign err_out       = r_err;
  assign rdata_out     = r_rdata;
  assign mst_write_out = r_mst_write;
  assign mst_cmd_out   = r_mst_cmd;
  assign mst_data_out  = r_mst_data;
  assign mst_nack_out  = r_mst_nack;

endmodule

// File: tb/tb_i2c_reg_xfer.sv
// Directed bench for i2c_reg_xfer with a behavioural master that records every command strobe.
`timescale 1ns/1ps
module tb_i2c_reg_xfer;
  import i2c_reg_xfer_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       start_in;
  logic       rw_in;
  logic [6:0] dev_addr_in;
  logic [7:0] reg_addr_in;
  logic [7:0] wdata_in;
  logic       busy_out;
  logic       done_out;
  logic       err_out;
  logic [7:0] rdata_out;
  logic       mst_write_out;
  logic [2:0] mst_cmd_out;
  logic [7:0] mst_data_out;
  logic       mst_nack_out;
  logic       mst_ready_in;
  logic [7:0] mst_rx_data_in;
  logic       mst_ack_in;

  always #5 clk_in = ~clk_in;

  i2c_reg_xfer #(.TIMEOUT_CYCLES(16'd100)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .rw_in(rw_in),
    .dev_addr_in(dev_addr_in), .reg_addr_in(reg_addr_in), .wdata_in(wdata_in),
    .busy_out(busy_out), .done_out(done_out), .err_out(err_out), .rdata_out(rdata_out),
    .mst_write_out(mst_write_out), .mst_cmd_out(mst_cmd_out), .mst_data_out(mst_data_out),
    .mst_nack_out(mst_nack_out), .mst_ready_in(mst_ready_in),
    .mst_rx_data_in(mst_rx_data_in), .mst_ack_in(mst_ack_in)
  );

  typedef struct packed {
    logic [2:0] cmd;
    logic [7:0] data;
    logic       nack;
  } strb_t;

  typedef struct {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] ra;
    logic [7:0] wd;
    logic [7:0] rx;
    int         nack_idx;
    int         n;
    logic       err;
    logic [7:0] rdata;
  } vec_t;

  vec_t  vecs[3];
  strb_t exp_strb[3][7];
  strb_t cap_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nack_idx = -1;
  int strobe_cyc = 0;
  int done_cyc = 0;
  logic mock_en = 1'b1;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Master model: ready drops 2 cycles after a strobe and returns 10 cycles later.
  initial begin
    mst_ready_in   = 1'b1;
    mst_ack_in     = 1'b1;
    mst_rx_data_in = 8'h00;
    forever begin
      @(posedge clk_in); #1;
      if (mst_write_out === 1'b1) begin
        strobe_cyc = cyc;
        mst_ack_in = (cap_q.size() != nack_idx);
        cap_q.push_back(strb_t'{mst_cmd_out, mst_data_out, mst_nack_out});
        if (mock_en) begin
          repeat (2) @(posedge clk_in);
          #1 mst_ready_in = 1'b0;
          repeat (10) @(posedge clk_in);
          #1 mst_ready_in = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic strb_t mk(input logic [2:0] c, input logic [7:0] d, input logic n);
    return strb_t'{c, d, n};
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},  32'(busy_out), 32'd0);
    chk({tag, "_done"},  32'(done_out), 32'd0);
    chk({tag, "_err"},   32'(err_out), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata_out), 32'd0);
    chk({tag, "_write"}, 32'(mst_write_out), 32'd0);
    chk({tag, "_cmd"},   32'(mst_cmd_out), 32'(k_STOP_CMD));
    chk({tag, "_data"},  32'(mst_data_out), 32'd0);
    chk({tag, "_nack"},  32'(mst_nack_out), 32'd0);
  endtask

  task automatic issue_start(input logic rw, input logic [6:0] dev,
                             input logic [7:0] ra, input logic [7:0] wd);
    @(negedge clk_in);
    start_in = 1'b1; rw_in = rw; dev_addr_in = dev; reg_addr_in = ra; wdata_in = wd;
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic run_txn(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                         input logic [7:0] wd, output int busy_low, output logic got_done);
    issue_start(rw, dev, ra, wd);
    busy_low = 0;
    got_done = 1'b0;
    for (int i = 0; i < 600 && !got_done; i++) begin
      if (done_out === 1'b1) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end else begin
        if (busy_out !== 1'b1) busy_low++;
        @(negedge clk_in);
      end
    end
  endtask

  initial begin
    int   busy_low;
    logic got_done;
    int   nsz;

    vecs[0] = '{rw: 1'b0, dev: 7'h50, ra: 8'h10, wd: 8'hA5, rx: 8'h00,
                nack_idx: -1, n: 5, err: 1'b0, rdata: 8'h00};
    exp_strb[0][0] = mk(k_START_CMD, 8'h00, 1'b0);
    exp_strb[0][1] = mk(k_WRITE_CMD, 8'hA0, 1'b1);
    exp_strb[0][2] = mk(k_WRITE_CMD, 8'h10, 1'b1);
    exp_strb[0][3] = mk(k_WRITE_CMD, 8'hA5, 1'b1);
    exp_strb[0][4] = mk(k_STOP_CMD,  8'h00, 1'b0);

    vecs[1] = '{rw: 1'b1, dev: 7'h50, ra: 8'h22, wd: 8'h00, rx: 8'h3C,
                nack_idx: -1, n: 7, err: 1'b0, rdata: 8'h3C};
    exp_strb[1][0] = mk(k_START_CMD,   8'h00, 1'b0);
    exp_strb[1][1] = mk(k_WRITE_CMD,   8'hA0, 1'b1);
    exp_strb[1][2] = mk(k_WRITE_CMD,   8'h22, 1'b1);
    exp_strb[1][3] = mk(k_RESTART_CMD, 8'h00, 1'b0);
    exp_strb[1][4] = mk(k_WRITE_CMD,   8'hA1, 1'b1);
    exp_strb[1][5] = mk(k_READ_CMD,    8'hFF, 1'b1);
    exp_strb[1][6] = mk(k_STOP_CMD,    8'h00, 1'b0);

    vecs[2] = '{rw: 1'b1, dev: 7'h50, ra: 8'h22, wd: 8'h00, rx: 8'h77,
                nack_idx: 1, n: 3, err: 1'b1, rdata: 8'h3C};
    exp_strb[2][0] = mk(k_START_CMD, 8'h00, 1'b0);
    exp_strb[2][1] = mk(k_WRITE_CMD, 8'hA0, 1'b1);
    exp_strb[2][2] = mk(k_STOP_CMD,  8'h00, 1'b0);

    rst_in = 1'b1; start_in = 1'b0; rw_in = 1'b0;
    dev_addr_in = 7'h00; reg_addr_in = 8'h00; wdata_in = 8'h00;
    repeat (3) @(negedge clk_in);
    check_reset("rst0");
    rst_in = 1'b0;

    for (int v = 0; v < 3; v++) begin
      cap_q.delete();
      nack_idx = vecs[v].nack_idx;
      mst_rx_data_in = vecs[v].rx;
      run_txn(vecs[v].rw, vecs[v].dev, vecs[v].ra, vecs[v].wd, busy_low, got_done);
      chk($sformatf("v%0d_done", v), 32'(got_done), 32'd1);
      chk($sformatf("v%0d_err", v), 32'(err_out), 32'(vecs[v].err));
      chk($sformatf("v%0d_busy_low", v), 32'(busy_low), 32'd0);
      @(negedge clk_in);
      chk($sformatf("v%0d_done_pulse", v), 32'(done_out), 32'd0);
      chk($sformatf("v%0d_busy_end", v), 32'(busy_out), 32'd0);
      chk($sformatf("v%0d_rdata", v), 32'(rdata_out), 32'(vecs[v].rdata));
      nsz = cap_q.size();
      chk($sformatf("v%0d_nstrobe", v), 32'(nsz), 32'(vecs[v].n));
      for (int i = 0; i < vecs[v].n; i++) begin
        if (i < nsz) begin
          chk($sformatf("v%0d_s%0d_cmd", v, i),  32'(cap_q[i].cmd),  32'(exp_strb[v][i].cmd));
          chk($sformatf("v%0d_s%0d_data", v, i), 32'(cap_q[i].data), 32'(exp_strb[v][i].data));
          chk($sformatf("v%0d_s%0d_nack", v, i), 32'(cap_q[i].nack), 32'(exp_strb[v][i].nack));
        end
      end
      repeat (3) @(negedge clk_in);
    end

    // Master never drops ready after the START strobe: abort from WAIT_LO without STOP.
    cap_q.delete();
    nack_idx = -1;
    mock_en = 1'b0;
    run_txn(1'b0, 7'h50, 8'h10, 8'h5A, busy_low, got_done);
    chk("tmo_done", 32'(got_done), 32'd1);
    chk("tmo_latency", 32'(done_cyc - strobe_cyc), 32'd100);
    chk("tmo_err", 32'(err_out), 32'd1);
    repeat (6) @(negedge clk_in);
    chk("tmo_nstrobe", 32'(cap_q.size()), 32'd1);
    chk("tmo_busy_end", 32'(busy_out), 32'd0);
    chk("tmo_rdata", 32'(rdata_out), 32'h3C);
    mock_en = 1'b1;

    // A second request while busy is ignored; then reset mid-read.
    cap_q.delete();
    mst_rx_data_in = 8'h99;
    issue_start(1'b1, 7'h50, 8'h22, 8'h00);
    repeat (20) @(negedge clk_in);
    issue_start(1'b0, 7'h11, 8'h33, 8'h44);
    for (int i = 0; i < 300 && cap_q.size() < 4; i++) @(negedge clk_in);
    nsz = cap_q.size();
    chk("ign_reached_restart", 32'(nsz >= 4), 32'd1);
    if (nsz >= 4) begin
      chk("ign_s1_data", 32'(cap_q[1].data), 32'hA0);
      chk("ign_s2_data", 32'(cap_q[2].data), 32'h22);
      chk("ign_s3_cmd",  32'(cap_q[3].cmd),  32'(k_RESTART_CMD));
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    check_reset("rst_mid");
    rst_in = 1'b0;
    repeat (30) @(negedge clk_in);
    chk("post_rst_nstrobe", 32'(cap_q.size()), 32'(nsz));
    chk("post_rst_busy", 32'(busy_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
